// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types, field layout and beat helper for the note sequencer
package music_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    localparam int DIV_W   = 12;
    localparam int DUR_W   = 4;
    localparam int ENTRY_W = 16;
    localparam int BEAT_W  = 5;

    localparam int DIV_LSB = 0;
    localparam int DIV_MSB = 11;
    localparam int DUR_LSB = 12;
    localparam int DUR_MSB = 15;

    // A zero duration field encodes the longest note, 16 beats.
    function automatic logic [BEAT_W-1:0] dur_beats(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? BEAT_W'(16) : BEAT_W'(dur);
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - note table write port bundle
interface note_sequencer_if;
    import music_pkg::*;

    logic               wr_en;
    logic [3:0]         wr_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic               wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/note_table.sv
// rtl/note_table.sv - DEPTH x 16 note register file, sync write, async read
module note_table
    import music_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - programmable melody scheduler driving the tone divider
module note_sequencer
    import music_pkg::*;
#(
    parameter  int DEPTH          = 16,
    parameter  int TICKS_PER_BEAT = 12000000,
    parameter  int GAP_TICKS      = 480000,
    localparam int IDX_W          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    note_sequencer_if.slave   wr,
    input  logic [IDX_W-1:0]  length,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic [DIV_W-1:0]  divider,
    output logic              gate,
    output logic [IDX_W-1:0]  note_idx,
    output logic              busy,
    output logic              done
);

    localparam int TICK_W = $clog2(TICKS_PER_BEAT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    // The gap always fits inside the last beat, so it starts at this tick of that beat.
    localparam logic [TICK_W-1:0] GAP_START = TICK_W'(TICKS_PER_BEAT - GAP_TICKS - 1);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]    len_q, len_d;
    logic [IDX_W-1:0]    idx_d;
    logic [IDX_W-1:0]    rd_addr;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [DIV_W-1:0]    div_d;
    logic                gate_d;
    logic                done_d;
    logic                load_entry;
    logic                has_next;
    logic                last_beat;
    logic                tbl_we;
    logic [ENTRY_W-1:0]  rd_data;

    assign has_next    = (note_idx != len_q);
    assign last_beat   = (beat_q == dur_beats(dur_q) - BEAT_W'(1));
    assign rd_addr     = (state_q == S_GAP && has_next) ? note_idx + IDX_W'(1) : '0;
    assign tbl_we      = wr.wr_en && (state_q == S_IDLE);
    assign wr.wr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);

    note_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .we      (tbl_we),
        .wr_addr (wr.wr_addr),
        .wr_data (wr.wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            dur_q    <= '0;
            divider  <= '0;
            gate     <= 1'b0;
            note_idx <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            dur_q    <= dur_d;
            divider  <= div_d;
            gate     <= gate_d;
            note_idx <= idx_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        beat_d     = beat_q;
        len_d      = len_q;
        dur_d      = dur_q;
        div_d      = divider;
        gate_d     = gate;
        idx_d      = note_idx;
        done_d     = 1'b0;
        load_entry = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    len_d   = length;
                end
            end
            S_LOAD: begin
                idx_d      = '0;
                load_entry = 1'b1;
            end
            S_PLAY, S_GAP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    beat_d = beat_q + BEAT_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
                if (state_q == S_PLAY && last_beat && tick_q == GAP_START) begin
                    state_d = S_GAP;
                    gate_d  = 1'b0;
                end else if (state_q == S_GAP && last_beat && tick_q == TICK_LAST) begin
                    if (has_next) begin
                        idx_d      = note_idx + IDX_W'(1);
                        load_entry = 1'b1;
                    end else if (loop) begin
                        idx_d      = '0;
                        load_entry = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tick_d  = '0;
                        beat_d  = '0;
                        div_d   = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Next entry is fetched through the async read port so no cycle is lost between notes.
        if (load_entry) begin
            state_d = S_PLAY;
            tick_d  = '0;
            beat_d  = '0;
            dur_d   = rd_data[DUR_MSB:DUR_LSB];
            div_d   = rd_data[DIV_MSB:DIV_LSB];
            gate_d  = (div_d != '0);
        end

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            tick_d  = '0;
            beat_d  = '0;
            div_d   = '0;
            gate_d  = 1'b0;
            idx_d   = '0;
            done_d  = 1'b0;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer with a note-list reference model
module tb_note_sequencer;

    localparam int T = 4;
    localparam int G = 1;

    typedef struct {
        int          c;
        int          scen;
        logic [11:0] div;
        logic        gate;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  length = '0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [11:0] divider;
    logic        gate;
    logic [3:0]  note_idx;
    logic        busy;
    logic        done;

    note_sequencer_if wif();

    note_sequencer #(
        .DEPTH          (16),
        .TICKS_PER_BEAT (T),
        .GAP_TICKS      (G)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wif.slave),
        .length   (length),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .divider  (divider),
        .gate     (gate),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    rec_t        q[$];
    rec_t        mon_e;
    logic [15:0] mtbl [16];
    int          cyc = 0;
    int          scen = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_sample scen=%0d cyc=%0d", q[0].scen, q[0].c);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].c == cyc) begin
            mon_e = q.pop_front();
            vectors++;
            if (divider !== mon_e.div || gate !== mon_e.gate || note_idx !== mon_e.idx) begin
                miscompares++;
                $display("FAIL data scen=%0d cyc=%0d got div=%0d gate=%0b idx=%0d exp div=%0d gate=%0b idx=%0d",
                         mon_e.scen, cyc, divider, gate, note_idx,
                         mon_e.div, mon_e.gate, mon_e.idx);
            end
            if (busy !== mon_e.busy || done !== mon_e.done || wif.wr_ready !== !mon_e.busy) begin
                miscompares++;
                $display("FAIL status scen=%0d cyc=%0d got busy=%0b done=%0b rdy=%0b exp busy=%0b done=%0b rdy=%0b",
                         mon_e.scen, cyc, busy, done, wif.wr_ready,
                         mon_e.busy, mon_e.done, !mon_e.busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [11:0] d, input logic g,
                        input logic [3:0] i, input logic b, input logic dn);
        rec_t r;
        r.c = c; r.scen = scen; r.div = d; r.gate = g; r.idx = i; r.busy = b; r.done = dn;
        q.push_back(r);
    endtask

    task automatic push_idle(input int c, input logic dn);
        push(c, 12'd0, 1'b0, 4'd0, 1'b0, dn);
    endtask

    function automatic int beats(input logic [15:0] e);
        return (e[15:12] == 4'd0) ? 16 : int'(e[15:12]);
    endfunction

    // Expected trace of a run started in cycle s; cut is the absolute cycle of stop/rst, or -1.
    task automatic build_trace(input int s, input int len, input bit lp, input int cut,
                               output int end_c);
        int c;
        int passes;
        bit fin;
        c = s + 1;
        passes = 0;
        fin = 1'b0;
        push(c, 12'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        c++;
        while (!fin) begin
            for (int k = 0; k <= len; k++) begin
                int n;
                logic [11:0] dv;
                n = beats(mtbl[k]) * T;
                dv = mtbl[k][11:0];
                for (int t = 0; t < n; t++) begin
                    if (cut < 0 || c <= cut)
                        push(c, dv, (dv != 12'd0) && (t < n - G), 4'(k), 1'b1, 1'b0);
                    c++;
                end
            end
            passes++;
            if (!lp || (cut >= 0 && c > cut) || passes >= 10) fin = 1'b1;
        end
        if (cut >= 0 && cut < c) begin
            push_idle(cut + 1, 1'b0);
            push_idle(cut + 2, 1'b0);
            end_c = cut + 2;
        end else begin
            push_idle(c, 1'b1);
            push_idle(c + 1, 1'b0);
            end_c = c + 1;
        end
    endtask

    task automatic write_entry(input int a, input logic [15:0] d);
        wif.wr_en = 1'b1;
        wif.wr_addr = 4'(a);
        wif.wr_data = d;
        mtbl[a] = d;
        tick();
        wif.wr_en = 1'b0;
    endtask

    task automatic drive_run(input int len, input bit lp, input int cut_rel,
                             input bit use_rst, input bit busy_wr);
        int s;
        int cut_abs;
        int end_c;
        length = 4'(len);
        loop = lp;
        start = 1'b1;
        s = cyc;
        cut_abs = (cut_rel < 0) ? -1 : s + cut_rel;
        build_trace(s, len, lp, cut_abs, end_c);
        tick();
        start = 1'b0;
        wif.wr_en = 1'b0;
        while (cyc <= end_c) begin
            stop = !use_rst && (cyc == cut_abs);
            rst = use_rst && (cyc == cut_abs);
            if (busy_wr && cyc == s + 3) begin
                wif.wr_en = 1'b1;
                wif.wr_addr = 4'd0;
                wif.wr_data = {4'd1, 12'd999};
            end else begin
                wif.wr_en = 1'b0;
            end
            tick();
        end
        stop = 1'b0;
        rst = 1'b0;
        wif.wr_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        miscompares++;
        $display("FAIL watchdog_timeout cyc=%0d pending=%0d", cyc, q.size());
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        wif.wr_en = 1'b0;
        wif.wr_addr = '0;
        wif.wr_data = '0;

        scen = 1;
        tick();
        tick();
        push_idle(cyc, 1'b0);
        rst = 1'b0;
        push_idle(cyc + 1, 1'b0);
        tick();
        tick();

        scen = 2;
        write_entry(0, {4'd1, 12'd1276});
        write_entry(1, {4'd2, 12'd1703});
        write_entry(2, {4'd1, 12'd1517});
        drive_run(2, 1'b0, -1, 1'b0, 1'b0);

        scen = 3;
        drive_run(2, 1'b0, -1, 1'b0, 1'b1);
        drive_run(2, 1'b0, -1, 1'b0, 1'b0);

        scen = 4;
        write_entry(0, {4'd2, 12'd0});
        write_entry(1, {4'd0, 12'd1912});
        drive_run(1, 1'b0, -1, 1'b0, 1'b0);

        scen = 5;
        write_entry(0, {4'd1, 12'd1276});
        write_entry(1, {4'd2, 12'd1703});
        drive_run(1, 1'b1, 20, 1'b0, 1'b0);

        scen = 6;
        length = 4'd2;
        loop = 1'b0;
        start = 1'b1;
        stop = 1'b1;
        push_idle(cyc + 1, 1'b0);
        push_idle(cyc + 2, 1'b0);
        tick();
        start = 1'b0;
        stop = 1'b0;
        tick();
        tick();

        scen = 7;
        wif.wr_en = 1'b1;
        wif.wr_addr = 4'd0;
        wif.wr_data = {4'd1, 12'd2000};
        mtbl[0] = {4'd1, 12'd2000};
        write_entry(2, {4'd1, 12'd1517});
        wif.wr_en = 1'b1;
        wif.wr_addr = 4'd0;
        wif.wr_data = {4'd1, 12'd2001};
        mtbl[0] = {4'd1, 12'd2001};
        drive_run(2, 1'b0, -1, 1'b0, 1'b0);

        scen = 8;
        drive_run(2, 1'b0, 5, 1'b1, 1'b0);
        tick();

        for (int r = 0; r < 25; r++) begin
            int len;
            int sum;
            int cut;
            bit lp;
            bit use_rst;
            bit bw;
            scen = 100 + r;
            len = $urandom_range(0, 4);
            for (int k = 0; k <= len; k++) begin
                logic [3:0]  du;
                logic [11:0] dv;
                du = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
                dv = ($urandom_range(0, 4) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
                write_entry(k, {du, dv});
            end
            sum = 0;
            for (int k = 0; k <= len; k++) sum += beats(mtbl[k]) * T;
            lp = $urandom_range(0, 1);
            if (lp)
                cut = $urandom_range(1, 2 * sum + 2);
            else
                cut = ($urandom_range(0, 1) == 1) ? $urandom_range(1, sum + 1) : -1;
            use_rst = ($urandom_range(0, 3) == 0);
            bw = (cut < 0 || cut >= 3) && ($urandom_range(0, 1) == 1);
            drive_run(len, lp, cut, use_rst, bw);
            tick();
        end

        tick();
        tick();
        while (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover scen=%0d cyc=%0d", q[0].scen, q[0].c);
            void'(q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
